// File: rtl/sfr_rd_word_packer.sv
// sfr_rd_word_packer: drains the byte-wide flash read FIFO into 32-bit valid/ready words
// while keeping a session CRC-32 and byte count.
module sfr_rd_word_packer #(
  parameter int CNT_W      = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic             CLK_25M_CKMNG_MAIN_PLD,
  input  logic             PWRGD_P1V2_MAX10_AUX_PLD_R,
  input  logic             session_start,
  input  logic             rd_completed,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_q,
  output logic             fifo_rdreq,
  output logic [31:0]      word_data,
  output logic [2:0]       word_bytes,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CNT_W-1:0] byte_count,
  output logic [31:0]      crc_out,
  output logic             crc_valid,
  output logic             rd_done
);
  typedef enum logic [2:0] {IDLE, POP, CAPT, PUSH, FLUSH, DONE} state_t;
  state_t r_state, w_next;
  logic [31:0] r_word, r_crc;
  logic [2:0] r_lane;
  logic [CNT_W-1:0] r_cnt;
  logic r_crc_valid;
  logic [1:0] w_pos;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  always_comb begin
    w_next = r_state;
    case (r_state)
      POP:     w_next = !fifo_empty ? CAPT : rd_completed ? (r_lane != 3'd0 ? FLUSH : DONE) : POP;
      CAPT:    w_next = r_lane == 3'd3 ? PUSH : POP;
      PUSH:    w_next = word_ready ? POP : PUSH;
      FLUSH:   w_next = word_ready ? DONE : FLUSH;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (session_start) w_next = POP;
  end
  always_ff @(posedge CLK_25M_CKMNG_MAIN_PLD) begin
    if (PWRGD_P1V2_MAX10_AUX_PLD_R) r_state <= IDLE;
    else r_state <= w_next;
  end
  // First byte lands in the low lane for little-endian, the high lane for big-endian
  assign w_pos = BIG_ENDIAN ? 2'd3 - r_lane[1:0] : r_lane[1:0];
  always_ff @(posedge CLK_25M_CKMNG_MAIN_PLD) begin
    if (PWRGD_P1V2_MAX10_AUX_PLD_R || session_start) begin
      r_word      <= '0;
      r_crc       <= 32'hFFFFFFFF;
      r_lane      <= 3'd0;
      r_cnt       <= '0;
      r_crc_valid <= 1'b0;
    end else begin
      if (r_state == CAPT) begin
        r_word[{w_pos, 3'b000} +: 8] <= fifo_q;
        r_crc  <= crc_byte(r_crc, fifo_q);
        r_cnt  <= r_cnt + CNT_W'(1);
        r_lane <= r_lane + 3'd1;
      end
      if (r_state == PUSH && word_ready) begin
        r_word <= '0;
        r_lane <= 3'd0;
      end
      if (w_next == DONE) r_crc_valid <= 1'b1;
    end
  end
  // A session_start in POP must not pop a byte the restarted session would never see
  assign fifo_rdreq = r_state == POP && !fifo_empty && !session_start;
  assign word_valid = r_state == PUSH || r_state == FLUSH;
  assign word_data  = word_valid ? r_word : '0;
  assign word_bytes = r_state == PUSH ? 3'd4 : r_state == FLUSH ? r_lane : 3'd0;
  assign byte_count = r_cnt;
  assign crc_out    = r_crc ^ 32'hFFFFFFFF;
  assign crc_valid  = r_crc_valid;
  assign rd_done    = r_state == DONE;
endmodule

// File: tb/tb_sfr_rd_word_packer.sv
// tb_sfr_rd_word_packer: table-driven, directed and random sessions against a queue/table model;
// a second big-endian instance with a 3-bit counter shares the stimulus.
module tb_sfr_rd_word_packer;
  logic clk = 0, rst = 1, session_start = 0, rd_completed = 0, word_ready = 1;
  logic fifo_empty;
  logic [7:0] fifo_q = 8'd0;
  logic fifo_rdreq, word_valid, crc_valid, rd_done;
  logic be_rdreq, be_valid, be_crc_valid, be_done;
  logic [31:0] word_data, crc_out, be_data, be_crc, byte_count;
  logic [2:0] word_bytes, be_bytes, be_count;

  sfr_rd_word_packer dut (
    .CLK_25M_CKMNG_MAIN_PLD(clk), .PWRGD_P1V2_MAX10_AUX_PLD_R(rst),
    .session_start(session_start), .rd_completed(rd_completed),
    .fifo_empty(fifo_empty), .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq),
    .word_data(word_data), .word_bytes(word_bytes), .word_valid(word_valid),
    .word_ready(word_ready), .byte_count(byte_count), .crc_out(crc_out),
    .crc_valid(crc_valid), .rd_done(rd_done));

  sfr_rd_word_packer #(.CNT_W(3), .BIG_ENDIAN(1'b1)) dut_be (
    .CLK_25M_CKMNG_MAIN_PLD(clk), .PWRGD_P1V2_MAX10_AUX_PLD_R(rst),
    .session_start(session_start), .rd_completed(rd_completed),
    .fifo_empty(fifo_empty), .fifo_q(fifo_q), .fifo_rdreq(be_rdreq),
    .word_data(be_data), .word_bytes(be_bytes), .word_valid(be_valid),
    .word_ready(word_ready), .byte_count(be_count), .crc_out(be_crc),
    .crc_valid(be_crc_valid), .rd_done(be_done));

  always #5 clk = ~clk;

  // FIFO model: pops on rdreq, data visible the following cycle; reset drains it
  logic [7:0] mem [4096];
  int wr_ptr = 0, rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (rst) begin
      rd_ptr <= wr_ptr;
      fifo_q <= 8'd0;
    end else if (fifo_rdreq) begin
      fifo_q <= mem[rd_ptr % 4096];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int ready_mode = 0;
  always @(negedge clk)
    word_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : (ready_mode == 0);

  logic [31:0] got_d[$], got_be[$];
  logic [2:0] got_b[$];
  int done_cnt = 0, viol = 0, stab_bad = 0;
  logic prev_stall = 0;
  logic [31:0] prev_d = 0;
  always @(negedge clk) begin
    #1;
    if (word_valid && word_ready) begin
      got_d.push_back(word_data);
      got_be.push_back(be_data);
      got_b.push_back(word_bytes);
    end
    if (rd_done) done_cnt++;
    if (fifo_rdreq && fifo_empty) viol++;
    if (prev_stall && !(word_valid && word_data == prev_d)) stab_bad++;
    prev_stall = word_valid && !word_ready;
    prev_d = word_data;
  end

  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  logic [31:0] crc_tab [256];
  function automatic logic [31:0] model_crc(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) c = crc_tab[(c[7:0] ^ q[i])] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic load_fifo(input logic [7:0] q[$]);
    foreach (q[i]) begin
      mem[wr_ptr % 4096] = q[i];
      wr_ptr++;
    end
  endtask

  task automatic start_session(input logic [7:0] q[$], input int mode, input bit comp);
    load_fifo(q);
    got_d.delete(); got_be.delete(); got_b.delete();
    done_cnt = 0;
    ready_mode = mode;
    rd_completed = 0;
    session_start = 1;
    @(negedge clk);
    session_start = 0;
    rd_completed = comp;
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget && done_cnt == 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_words(input string tag, input logic [7:0] q[$]);
    int nw;
    nw = (q.size() + 3) / 4;
    chk({tag, "_nwords"}, 64'(got_d.size()), 64'(nw));
    for (int i = 0; i < nw && i < got_d.size(); i++) begin
      logic [31:0] le, be;
      int nb;
      le = 0; be = 0;
      nb = q.size() - 4 * i;
      if (nb > 4) nb = 4;
      for (int k = 0; k < nb; k++) begin
        le |= 32'(q[4*i+k]) << (8 * k);
        be |= 32'(q[4*i+k]) << (24 - 8 * k);
      end
      chk({tag, "_word_le"}, got_d[i], le);
      chk({tag, "_word_be"}, got_be[i], be);
      chk({tag, "_bytes"}, got_b[i], 64'(nb));
    end
    chk({tag, "_crc"}, crc_out, model_crc(q));
    chk({tag, "_crc_be"}, be_crc, model_crc(q));
    chk({tag, "_crc_valid"}, {crc_valid, be_crc_valid}, 2'b11);
    chk({tag, "_rd_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_byte_count"}, byte_count, 64'(q.size()));
    chk({tag, "_byte_count_wrap"}, be_count, 64'(q.size() % 8));
  endtask

  typedef struct {
    int n; logic [7:0] base; int words; int last_b; int cnt; bit has_crc; logic [31:0] crc;
  } vec_t;
  vec_t tab[8];

  initial begin
    logic [7:0] q[$];
    logic [31:0] d;
    int stable;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
      crc_tab[i] = c;
    end
    tab[0] = '{0,  8'h00, 0, 0, 0,  1, 32'h00000000};
    tab[1] = '{9,  8'h31, 3, 1, 9,  1, 32'hCBF43926};
    tab[2] = '{8,  8'h00, 2, 4, 8,  0, 32'h0};
    tab[3] = '{1,  8'hAA, 1, 1, 1,  0, 32'h0};
    tab[4] = '{3,  8'h10, 1, 3, 3,  0, 32'h0};
    tab[5] = '{4,  8'h20, 1, 4, 4,  0, 32'h0};
    tab[6] = '{5,  8'h30, 2, 1, 5,  0, 32'h0};
    tab[7] = '{13, 8'h40, 4, 1, 13, 0, 32'h0};

    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_flags", {word_valid, fifo_rdreq, rd_done, crc_valid, be_valid}, 5'd0);
    chk("rst_word", {word_data, 5'd0, word_bytes}, 64'd0);
    chk("rst_count_crc", {byte_count, crc_out}, 64'd0);

    foreach (tab[i]) begin
      q.delete();
      for (int k = 0; k < tab[i].n; k++) q.push_back(tab[i].base + 8'(k));
      start_session(q, 0, 1);
      wait_done(500);
      check_words($sformatf("tab%0d", i), q);
      chk($sformatf("tab%0d_words_const", i), 64'(got_d.size()), 64'(tab[i].words));
      chk($sformatf("tab%0d_last_bytes", i), got_b.size() > 0 ? 64'(got_b[got_b.size()-1]) : 64'd0,
          64'(tab[i].last_b));
      chk($sformatf("tab%0d_cnt_const", i), byte_count, 64'(tab[i].cnt));
      if (tab[i].has_crc) chk($sformatf("tab%0d_crc_const", i), crc_out, tab[i].crc);
    end

    // back-pressure in PUSH while more bytes wait in the FIFO
    q.delete();
    for (int k = 0; k < 8; k++) q.push_back(8'h50 + 8'(k));
    start_session(q, 2, 1);
    for (int c = 0; c < 100 && !word_valid; c++) @(negedge clk);
    chk("stall_reach_push", word_valid, 1'b1);
    d = word_data;
    chk("stall_word", d, 32'h53525150);
    stable = 0;
    repeat (20) begin
      @(negedge clk);
      if (word_valid && word_data == d && word_bytes == 3'd4 && !fifo_rdreq) stable++;
    end
    chk("stall_stable_cycles", 64'(stable), 64'd20);
    ready_mode = 0;
    wait_done(500);
    check_words("stall", q);

    // abort after 5 bytes, then restart with two bytes
    q.delete();
    for (int k = 0; k < 5; k++) q.push_back(8'h60 + 8'(k));
    start_session(q, 0, 0);
    for (int c = 0; c < 100 && byte_count != 32'd5; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("abort_pre_count", byte_count, 64'd5);
    session_start = 1;
    @(negedge clk);
    session_start = 0;
    repeat (4) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_count_clr", byte_count, 64'd0);
    got_d.delete(); got_be.delete(); got_b.delete();
    q.delete();
    q.push_back(8'hAA);
    q.push_back(8'hBB);
    load_fifo(q);
    rd_completed = 1;
    wait_done(500);
    check_words("abort", q);
    chk("abort_word_le", got_d.size() > 0 ? got_d[0] : 32'd0, 32'h0000BBAA);
    chk("abort_word_be", got_be.size() > 0 ? got_be[0] : 32'd0, 32'hAABB0000);

    // reset in the middle of a session
    q.delete();
    for (int k = 0; k < 10; k++) q.push_back(8'h70 + 8'(k));
    start_session(q, 0, 1);
    repeat (6) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("midrst_flags", {word_valid, fifo_rdreq, rd_done, crc_valid}, 4'd0);
    chk("midrst_count_crc", {byte_count, crc_out}, 64'd0);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    chk("midrst_idle", {fifo_rdreq, word_valid, fifo_empty}, 3'b001);

    for (int r = 0; r < 15; r++) begin
      q.delete();
      for (int k = 0, n = $urandom_range(0, 20); k < n; k++) q.push_back(8'($urandom));
      start_session(q, 1, 1);
      wait_done(2000);
      check_words($sformatf("rnd%0d", r), q);
    end

    chk("rdreq_while_empty", 64'(viol), 64'd0);
    chk("word_stable_under_stall", 64'(stab_bad), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
